// File: rtl/bp_l15_resp_pkg.sv
// Shared types and constants for the L1.5 responder model.
// Holds the FSM state enum, the L1.5 request/return type codes, the PCX size codes
// and the byte-mask helper.
// The L15_RESP_LATENCY_EN macro adds the e_wait state to the enum.
package bp_l15_resp_pkg;

    // Request types
    localparam logic [4:0] LOAD_RQ    = 5'b00000;
    localparam logic [4:0] STORE_RQ   = 5'b00001;

    // Return types
    localparam logic [3:0] LOAD_RET   = 4'b0000;
    localparam logic [3:0] ST_ACK     = 4'b0100;
    localparam logic [3:0] INT_RET    = 4'b0111;

    // PCX size codes
    localparam logic [2:0] PCX_SZ_1B  = 3'b000;
    localparam logic [2:0] PCX_SZ_2B  = 3'b001;
    localparam logic [2:0] PCX_SZ_4B  = 3'b010;
    localparam logic [2:0] PCX_SZ_8B  = 3'b011;
    localparam logic [2:0] PCX_SZ_16B = 3'b111;

    typedef enum logic [2:0] {
        e_rst  = 3'd0,
        e_int  = 3'd1,
        e_idle = 3'd2,
`ifdef L15_RESP_LATENCY_EN
        e_wait = 3'd3,
`endif
        e_resp = 3'd4
    } state_e;

    // Bytes of a 16-byte line covered by an access of the given PCX size at the
    // given byte offset.
    function automatic logic [15:0] byte_mask(input logic [2:0] size, input logic [3:0] offset);
        logic [15:0] base;
        case (size)
            PCX_SZ_1B:  base = 16'h0001;
            PCX_SZ_2B:  base = 16'h0003;
            PCX_SZ_4B:  base = 16'h000F;
            PCX_SZ_8B:  base = 16'h00FF;
            PCX_SZ_16B: base = 16'hFFFF;
            default:    base = 16'h0000;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/bp_l15_resp_mem.sv
// Backing line store: els_p x 128-bit flop array, cleared asynchronously on reset.
// Latency: combinational read, write lands at the clock edge.
// Backpressure: none; the single write port is taken whenever w_v_i is high.
// Ports: clk_i/reset_n_i, r_idx_i -> r_data_o (read), w_v_i/w_idx_i/w_mask_i/w_data_i (byte-masked write).
module bp_l15_resp_mem #(
    parameter int els_p = 64,
    localparam int IDX_W = $clog2(els_p)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [IDX_W-1:0] r_idx_i,
    output logic [127:0]     r_data_o,
    input  logic             w_v_i,
    input  logic [IDX_W-1:0] w_idx_i,
    input  logic [15:0]      w_mask_i,
    input  logic [127:0]     w_data_i
);

    logic [127:0] mem_q [els_p];

    assign r_data_o = mem_q[r_idx_i];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_v_i) begin
            for (int b = 0; b < 16; b++) begin
                if (w_mask_i[b]) begin
                    mem_q[w_idx_i][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/bp_l15_resp_model.sv
// L1.5-side responder: acks LOAD_RQ/STORE_RQ and returns LOAD_RET/ST_ACK from a line store; INT_RET after reset.
// Latency: ack combinational in idle; response valid 1 cycle after ack (latency_p+1 with L15_RESP_LATENCY_EN).
// Backpressure: one request outstanding; response held until transducer_l15_req_ack, no ack outside idle.
// Ports: transducer_l15_* request bus in, l15_transducer_* response bus out, transducer_l15_req_ack, error_o (sticky).
// Build option: define L15_RESP_LATENCY_EN to insert the latency_p-cycle e_wait state.
module bp_l15_resp_model
    import bp_l15_resp_pkg::*;
#(
    parameter int mem_els_p = 64,
    parameter int latency_p = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,

    input  logic        transducer_l15_val,
    input  logic [4:0]  transducer_l15_rqtype,
    input  logic [2:0]  transducer_l15_size,
    input  logic [39:0] transducer_l15_address,
    input  logic [63:0] transducer_l15_data,
    input  logic [1:0]  transducer_l15_l1rplway,
    output logic        l15_transducer_ack,
    output logic        l15_transducer_header_ack,

    output logic        l15_transducer_val,
    output logic [3:0]  l15_transducer_returntype,
    output logic [63:0] l15_transducer_data_0,
    output logic [63:0] l15_transducer_data_1,
    input  logic        transducer_l15_req_ack,

    output logic        error_o
);

    localparam int IDX_W = $clog2(mem_els_p);

    state_e       state_q, state_d;
    logic         val_q, val_d;
    logic [3:0]   rtype_q, rtype_d;
    logic [127:0] data_q, data_d;
    logic         err_q, err_d;

`ifdef L15_RESP_LATENCY_EN
    localparam int CNT_W = $clog2(latency_p + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_latency = latency_p;
`endif

    // Request decode
    logic [IDX_W-1:0] line_idx;
    logic [127:0]     rd_line;
    logic             is_load, is_store, size_ok, misaligned, store_ok, bad_req, ack;

    assign line_idx = transducer_l15_address[4 +: IDX_W];
    assign is_load  = (transducer_l15_rqtype == LOAD_RQ);
    assign is_store = (transducer_l15_rqtype == STORE_RQ);
    assign size_ok  = (transducer_l15_size == PCX_SZ_1B) || (transducer_l15_size == PCX_SZ_2B)
                   || (transducer_l15_size == PCX_SZ_4B) || (transducer_l15_size == PCX_SZ_8B);

    always_comb begin
        misaligned = 1'b0;
        case (transducer_l15_size)
            PCX_SZ_2B: misaligned = transducer_l15_address[0];
            PCX_SZ_4B: misaligned = |transducer_l15_address[1:0];
            PCX_SZ_8B: misaligned = |transducer_l15_address[2:0];
            default:   misaligned = 1'b0;
        endcase
    end

    assign store_ok = is_store && size_ok && !misaligned;
    assign bad_req  = !is_load && !store_ok;
    assign ack      = (state_q == e_idle) && transducer_l15_val;

    // Store data is replicated to both halves so each line byte picks up the
    // data lane matching its position within the aligned 8-byte word.
    bp_l15_resp_mem #(.els_p(mem_els_p)) mem (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .r_idx_i   (line_idx),
        .r_data_o  (rd_line),
        .w_v_i     (ack && store_ok),
        .w_idx_i   (line_idx),
        .w_mask_i  (byte_mask(transducer_l15_size, transducer_l15_address[3:0])),
        .w_data_i  ({transducer_l15_data, transducer_l15_data})
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rtype_d = rtype_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef L15_RESP_LATENCY_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            e_rst: begin
                state_d = e_int;
                val_d   = 1'b1;
                rtype_d = INT_RET;
                data_d  = '0;
            end
            e_int: begin
                if (transducer_l15_req_ack) begin
                    val_d   = 1'b0;
                    state_d = e_idle;
                end
            end
            e_idle: begin
                if (ack) begin
                    // Response payload is captured here; the line cannot change
                    // again before the response is consumed.
                    rtype_d = is_load ? LOAD_RET : ST_ACK;
                    data_d  = is_load ? rd_line : '0;
                    if (bad_req) begin
                        err_d = 1'b1;
                    end
`ifdef L15_RESP_LATENCY_EN
                    if (latency_p == 0) begin
                        state_d = e_resp;
                        val_d   = 1'b1;
                    end else begin
                        state_d = e_wait;
                        cnt_d   = CNT_W'(latency_p - 1);
                    end
`else
                    state_d = e_resp;
                    val_d   = 1'b1;
`endif
                end
            end
`ifdef L15_RESP_LATENCY_EN
            e_wait: begin
                if (cnt_q == '0) begin
                    state_d = e_resp;
                    val_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            e_resp: begin
                if (transducer_l15_req_ack) begin
                    val_d   = 1'b0;
                    state_d = e_idle;
                end
            end
            default: state_d = e_rst;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_rst;
            val_q   <= 1'b0;
            rtype_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef L15_RESP_LATENCY_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            rtype_q <= rtype_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef L15_RESP_LATENCY_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign l15_transducer_ack        = ack;
    assign l15_transducer_header_ack = ack;
    assign l15_transducer_val        = val_q;
    assign l15_transducer_returntype = rtype_q;
    assign l15_transducer_data_0     = data_q[63:0];
    assign l15_transducer_data_1     = data_q[127:64];
    assign error_o                   = err_q;

    logic unused_bits;
    assign unused_bits = ^{transducer_l15_l1rplway, transducer_l15_address[39:4+IDX_W]};

endmodule

// File: tb/tb_bp_l15_resp_model.sv
module tb_bp_l15_resp_model;

    localparam int MEM_ELS = 64;
    localparam int LAT     = 4;
    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;
    localparam logic [4:0] RQ_IMISS = 5'b10000;
    localparam logic [3:0] RT_LOAD  = 4'b0000;
    localparam logic [3:0] RT_STACK = 4'b0100;
    localparam logic [3:0] RT_INT   = 4'b0111;
`ifdef L15_RESP_LATENCY_EN
    localparam int EXP_LAT = LAT + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk, rst_n;
    logic        t_val, req_ack;
    logic [4:0]  t_rqtype;
    logic [2:0]  t_size;
    logic [39:0] t_addr;
    logic [63:0] t_data;
    logic [1:0]  t_way;
    logic        ack, hdr_ack, r_val, err;
    logic [3:0]  r_rt;
    logic [63:0] r_d0, r_d1;

    bp_l15_resp_model #(.mem_els_p(MEM_ELS), .latency_p(LAT)) dut (
        .clk_i                     (clk),
        .reset_n_i                 (rst_n),
        .transducer_l15_val        (t_val),
        .transducer_l15_rqtype     (t_rqtype),
        .transducer_l15_size       (t_size),
        .transducer_l15_address    (t_addr),
        .transducer_l15_data       (t_data),
        .transducer_l15_l1rplway   (t_way),
        .l15_transducer_ack        (ack),
        .l15_transducer_header_ack (hdr_ack),
        .l15_transducer_val        (r_val),
        .l15_transducer_returntype (r_rt),
        .l15_transducer_data_0     (r_d0),
        .l15_transducer_data_1     (r_d1),
        .transducer_l15_req_ack    (req_ack),
        .error_o                   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flat byte image of the store plus the sticky error flag.
    logic [7:0]  ref_mem [MEM_ELS*16];
    bit          ref_err;
    int          vec, errs;
    logic [3:0]  last_rt;
    logic [63:0] last_d0, last_d1;

    function automatic void ref_clear();
        for (int i = 0; i < MEM_ELS*16; i++) ref_mem[i] = 8'h00;
        ref_err = 1'b0;
    endfunction

    // One complete request/response exchange. Called in an idle cycle just after
    // a negedge; returns just after the negedge following the req_ack edge.
    task automatic txn(input logic [4:0] rt, input logic [2:0] sz, input logic [39:0] a,
                       input logic [63:0] d, input int stall);
        longint unsigned ua, base;
        int              off, nb, n;
        logic [127:0]    exp_line;
        logic [3:0]      exp_rt, h_rt;
        logic [63:0]     h_d0, h_d1;
        bit              store_ok, stray, bad_hold;
        ua       = a;
        base     = ((ua >> 4) % MEM_ELS) * 16;
        off      = int'(ua % 16);
        exp_line = '0;
        if (rt == RQ_LOAD) begin
            exp_rt = RT_LOAD;
            for (int k = 0; k < 16; k++) exp_line[8*k +: 8] = ref_mem[base + k];
        end else begin
            exp_rt   = RT_STACK;
            store_ok = 1'b0;
            if (rt == RQ_STORE && sz <= 3) begin
                nb = 1 << sz;
                store_ok = ((ua % nb) == 0);
            end
            if (store_ok) begin
                for (int k = 0; k < nb; k++)
                    ref_mem[base + off + k] = d[8*(int'(ua % 8) + k) +: 8];
            end else begin
                ref_err = 1'b1;
            end
        end

        t_val = 1'b1; t_rqtype = rt; t_size = sz; t_addr = a; t_data = d;
        t_way = 2'($urandom);
        #1;
        vec++;
        if (ack !== 1'b1 || hdr_ack !== 1'b1)
            begin errs++; $display("FAIL ack_in_idle addr=%h got ack=%b hdr=%b expected 1/1", a, ack, hdr_ack); end
        @(posedge clk);
        // Keep presenting the request: no further ack may appear outside idle.
        stray = 1'b0; bad_hold = 1'b0;
        @(negedge clk); #1; n = 1;
        while (r_val !== 1'b1 && n < 100) begin
            if (ack !== 1'b0) stray = 1'b1;
            @(negedge clk); #1; n++;
        end
        vec++;
        if (n != EXP_LAT)
            begin errs++; $display("FAIL resp_latency addr=%h got %0d cycles expected %0d", a, n, EXP_LAT); end
        vec++;
        if (r_rt !== exp_rt || {r_d1, r_d0} !== exp_line)
            begin errs++; $display("FAIL resp_data addr=%h got rt=%h d1=%h d0=%h expected rt=%h d1=%h d0=%h",
                                   a, r_rt, r_d1, r_d0, exp_rt, exp_line[127:64], exp_line[63:0]); end
        h_rt = r_rt; h_d0 = r_d0; h_d1 = r_d1;
        last_rt = r_rt; last_d0 = r_d0; last_d1 = r_d1;
        repeat (stall) begin
            @(negedge clk); #1;
            if (ack !== 1'b0) stray = 1'b1;
            if (r_val !== 1'b1 || r_rt !== h_rt || r_d0 !== h_d0 || r_d1 !== h_d1) bad_hold = 1'b1;
        end
        req_ack = 1'b1; t_val = 1'b0;
        #1;
        if (r_val !== 1'b1 || r_rt !== h_rt || r_d0 !== h_d0 || r_d1 !== h_d1) bad_hold = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        #1;
        vec++;
        if (r_val !== 1'b0)
            begin errs++; $display("FAIL val_drop addr=%h got val=%b expected 0", a, r_val); end
        vec++;
        if (stray || bad_hold)
            begin errs++; $display("FAIL hold_noack addr=%h got stray_ack=%b unstable=%b expected 0/0", a, stray, bad_hold); end
        vec++;
        if (err !== ref_err)
            begin errs++; $display("FAIL error_flag addr=%h got %b expected %b", a, err, ref_err); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_ack = 1'b0;
        t_val = 1'b1; t_rqtype = RQ_LOAD; t_size = 3'd3; t_addr = '0; t_data = '0; t_way = '0;
        ref_clear();
        #12;
        vec++;
        if (r_val !== 1'b0 || r_rt !== 4'h0 || r_d0 !== 64'h0 || r_d1 !== 64'h0)
            begin errs++; $display("FAIL reset_resp got val=%b rt=%h d1=%h d0=%h expected all 0", r_val, r_rt, r_d1, r_d0); end
        vec++;
        if (ack !== 1'b0 || hdr_ack !== 1'b0 || err !== 1'b0)
            begin errs++; $display("FAIL reset_ctrl got ack=%b hdr=%b err=%b expected 0/0/0", ack, hdr_ack, err); end
    endtask

    // Releases reset, checks the INT_RET wakeup and its consumption.
    task automatic test_int_ret();
        @(negedge clk);
        rst_n = 1'b1; t_val = 1'b1; t_rqtype = RQ_LOAD; t_addr = 40'h40;
        #1;
        vec++;
        if (r_val !== 1'b0 || ack !== 1'b0)
            begin errs++; $display("FAIL rst_cycle got val=%b ack=%b expected 0/0", r_val, ack); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            vec++;
            if (r_val !== 1'b1 || r_rt !== RT_INT || r_d0 !== 64'h0 || r_d1 !== 64'h0 || ack !== 1'b0)
                begin errs++; $display("FAIL int_ret cyc=%0d got val=%b rt=%h d1=%h d0=%h ack=%b expected 1/%h/0/0/0",
                                       i, r_val, r_rt, r_d1, r_d0, ack, RT_INT); end
        end
        req_ack = 1'b1; t_val = 1'b0;
        // req_ack stays high one more cycle with val low: must be ignored.
        @(negedge clk); #1;
        vec++;
        if (r_val !== 1'b0)
            begin errs++; $display("FAIL int_consume got val=%b expected 0", r_val); end
        @(negedge clk);
        req_ack = 1'b0;
        #1;
        vec++;
        if (r_val !== 1'b0)
            begin errs++; $display("FAIL stray_req_ack got val=%b expected 0", r_val); end
    endtask

    task automatic test_load_zero();
        txn(RQ_LOAD, 3'd3, 40'h40, 64'h0, 0);
        vec++;
        if (last_rt !== RT_LOAD || last_d0 !== 64'h0 || last_d1 !== 64'h0)
            begin errs++; $display("FAIL load_zero got rt=%h d1=%h d0=%h expected %h/0/0", last_rt, last_d1, last_d0, RT_LOAD); end
    endtask

    task automatic test_store_load();
        txn(RQ_STORE, 3'd3, 40'h48, 64'hDEADBEEF_01234567, 1);
        vec++;
        if (last_rt !== RT_STACK || last_d0 !== 64'h0 || last_d1 !== 64'h0)
            begin errs++; $display("FAIL store_ack got rt=%h d1=%h d0=%h expected %h/0/0", last_rt, last_d1, last_d0, RT_STACK); end
        txn(RQ_LOAD, 3'd3, 40'h40, 64'h0, 0);
        vec++;
        if (last_d1 !== 64'hDEADBEEF_01234567 || last_d0 !== 64'h0)
            begin errs++; $display("FAIL store8_load got d1=%h d0=%h expected deadbeef01234567/0", last_d1, last_d0); end
    endtask

    task automatic test_store_byte();
        txn(RQ_STORE, 3'd0, 40'h43, 64'h00000000_AA000000, 2);
        txn(RQ_LOAD, 3'd3, 40'h40, 64'h0, 0);
        vec++;
        if (last_d0 !== 64'h00000000_AA000000 || last_d1 !== 64'hDEADBEEF_01234567)
            begin errs++; $display("FAIL store1_load got d1=%h d0=%h expected deadbeef01234567/aa000000", last_d1, last_d0); end
    endtask

    task automatic test_misaligned();
        txn(RQ_STORE, 3'd2, 40'h42, 64'hFFFFFFFF_FFFFFFFF, 0);
        vec++;
        if (last_rt !== RT_STACK || err !== 1'b1)
            begin errs++; $display("FAIL misaligned got rt=%h err=%b expected %h/1", last_rt, err, RT_STACK); end
        txn(RQ_STORE, 3'd7, 40'h40, 64'hFFFFFFFF_FFFFFFFF, 0);
        txn(RQ_IMISS, 3'd3, 40'h40, 64'hFFFFFFFF_FFFFFFFF, 0);
        txn(RQ_LOAD, 3'd3, 40'h40, 64'h0, 0);
        vec++;
        if (last_d0 !== 64'h00000000_AA000000 || last_d1 !== 64'hDEADBEEF_01234567)
            begin errs++; $display("FAIL bad_store_nowrite got d1=%h d0=%h expected deadbeef01234567/aa000000", last_d1, last_d0); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] s0, s1;
        s0 = {$urandom, $urandom}; s1 = {$urandom, $urandom};
        txn(RQ_STORE, 3'd3, 40'h1000, s0, 0);
        txn(RQ_STORE, 3'd3, 40'h1008, s1, 0);
        for (int i = 0; i < 4; i++) txn(RQ_LOAD, 3'd7, 40'h1000 + 40'(16*i), 64'h0, 3);
        txn(RQ_LOAD, 3'd7, 40'h1000 + 40'(16*MEM_ELS), 64'h0, 3);
        vec++;
        if (last_d0 !== s0 || last_d1 !== s1)
            begin errs++; $display("FAIL alias got d1=%h d0=%h expected %h/%h", last_d1, last_d0, s1, s0); end
    endtask

    task automatic test_random();
        logic [4:0]  rt;
        logic [2:0]  sz;
        logic [39:0] a;
        int          pick;
        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 19);
            rt = (pick < 9) ? RQ_LOAD : (pick < 18) ? RQ_STORE : RQ_IMISS;
            sz = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
            a  = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) != 0) a = a & ~40'h7;
            txn(rt, sz, a, {$urandom, $urandom}, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        t_val = 1'b1; t_rqtype = RQ_LOAD; t_size = 3'd3; t_addr = 40'h48;
        #1;
        @(posedge clk);
        @(negedge clk);
        t_val = 1'b0;
        repeat (EXP_LAT - 1) @(negedge clk);
        #1;
        vec++;
        if (r_val !== 1'b1)
            begin errs++; $display("FAIL mid_resp_up got val=%b expected 1", r_val); end
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (r_val !== 1'b0 || r_d0 !== 64'h0 || r_d1 !== 64'h0 || r_rt !== 4'h0 || err !== 1'b0)
            begin errs++; $display("FAIL mid_reset got val=%b rt=%h d1=%h d0=%h err=%b expected all 0",
                                   r_val, r_rt, r_d1, r_d0, err); end
        ref_clear();
        test_int_ret();
        txn(RQ_LOAD, 3'd3, 40'h40, 64'h0, 0);
        vec++;
        if (last_d0 !== 64'h0 || last_d1 !== 64'h0)
            begin errs++; $display("FAIL mem_cleared got d1=%h d0=%h expected 0/0", last_d1, last_d0); end
    endtask

    initial begin
        vec = 0; errs = 0;
        test_reset();
        test_int_ret();
        test_load_zero();
        test_store_load();
        test_store_byte();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
